ram_loader: RTL and testbench



---
 rtl/ram_loader.sv | 174 +++++++++++++++++
 tb/tb_ram_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: boot-time image loader sitting in front of the NBBPU RAM.
// Takes a byte stream (count_lo, count_hi, N little-endian words, XOR checksum),
// assembles 16-bit words and writes them with single-cycle registered strobes.
// Reports busy/done/error to the boot logic. done and error are sticky until reset.
module ram_loader #(
   parameter int unsigned DEPTH        = 256,
   parameter logic [15:0] BASE_ADDRESS = 16'h0000,
   parameter int unsigned TIMEOUT      = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        ram_select,
   output logic        ram_write_enable,
   output logic [15:0] ram_address,
   output logic [15:0] ram_write_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      CNT_LO,
      CNT_HI,
      DATA_LO,
      DATA_HI,
      CHECK,
      DONE,
      ERROR
   } state_t;

   // One RAM write request. It is driven for one cycle and is all-zero otherwise.
   typedef struct packed {
      logic        sel;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } ram_wr_t;

   state_t        state_q, state_d;
   logic [15:0]   count_q, count_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    lo_q, lo_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   wl_q, wl_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   ram_wr_t       wr_q, wr_d;

   logic [15:0]   hdr_count;
   logic          timeout_hit;

   assign hdr_count   = {rx_data, count_q[7:0]};
   assign timeout_hit = busy_q && !rx_valid && (timer_q == TW'(TIMEOUT - 1));

   // Next-state logic. Bytes are consumed only on rx_valid. The write request
   // defaults to zero, so every strobe lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      csum_d  = csum_q;
      lo_d    = lo_q;
      timer_d = timer_q;
      wl_d    = wl_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      wr_d    = '0;

      // The idle timer runs only while a transfer is open. It restarts on every byte.
      if (rx_valid) begin
         timer_d = '0;
      end else if (busy_q) begin
         timer_d = timer_q + 1'b1;
      end

      if (timeout_hit) begin
         state_d = ERROR;
         error_d = 1'b1;
         busy_d  = 1'b0;
      end

      if (rx_valid) begin
         case (state_q)
            CNT_LO: begin
               count_d[7:0] = rx_data;
               csum_d       = csum_q ^ rx_data;
               state_d      = CNT_HI;
            end
            CNT_HI: begin
               count_d[15:8] = rx_data;
               csum_d        = csum_q ^ rx_data;
               busy_d        = 1'b1;
               if ({1'b0, hdr_count} > 17'(DEPTH)) begin
                  state_d = ERROR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else if (hdr_count == 16'd0) begin
                  state_d = CHECK;
               end else begin
                  state_d = DATA_LO;
               end
            end
            DATA_LO: begin
               lo_d    = rx_data;
               csum_d  = csum_q ^ rx_data;
               state_d = DATA_HI;
            end
            DATA_HI: begin
               csum_d      = csum_q ^ rx_data;
               wr_d.sel    = 1'b1;
               wr_d.we     = 1'b1;
               wr_d.addr   = BASE_ADDRESS + wl_q;
               wr_d.data   = {rx_data, lo_q};
               wl_d        = wl_q + 16'd1;
               state_d     = ((wl_q + 16'd1) == count_q) ? CHECK : DATA_LO;
            end
            CHECK: begin
               busy_d = 1'b0;
               if (rx_data == csum_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end
            default: ;  // DONE / ERROR: terminal, bytes ignored
         endcase
      end
   end

   // State and registered outputs. Reset aborts any transfer at once.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= CNT_LO;
         count_q <= '0;
         csum_q  <= '0;
         lo_q    <= '0;
         timer_q <= '0;
         wl_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         csum_q  <= csum_d;
         lo_q    <= lo_d;
         timer_q <= timer_d;
         wl_q    <= wl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         wr_q    <= wr_d;
      end
   end

   assign ram_select       = wr_q.sel;
   assign ram_write_enable = wr_q.we;
   assign ram_address      = wr_q.addr;
   assign ram_write_data   = wr_q.data;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign words_loaded     = wl_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader. It uses TIMEOUT=16 so that the idle timeout is reachable.
module tb_ram_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        ram_select;
   logic        ram_write_enable;
   logic [15:0] ram_address;
   logic [15:0] ram_write_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;

   ram_loader #(
      .DEPTH        (256),
      .BASE_ADDRESS (16'h0000),
      .TIMEOUT      (16)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .ram_select       (ram_select),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_write_data   (ram_write_data),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .words_loaded     (words_loaded)
   );

   always #5 clock = ~clock;

   // Logs every RAM strobe seen at an edge. A strobe that lasts two cycles is logged twice.
   int          wr_n = 0;
   int          bad_pair = 0;
   logic [15:0] log_addr [0:31];
   logic [15:0] log_data [0:31];
   always @(posedge clock) begin
      if (ram_select !== ram_write_enable) bad_pair++;
      if (ram_select === 1'b1) begin
         if (wr_n < 32) begin
            log_addr[wr_n] = ram_address;
            log_data[wr_n] = ram_write_data;
         end
         wr_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   int base;

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_sel",   ram_select,       1'b0);
      chk("rst_we",    ram_write_enable, 1'b0);
      chk("rst_addr",  ram_address,      16'h0);
      chk("rst_data",  ram_write_data,   16'h0);
      chk("rst_flags", {busy, done, error}, 3'b000);
      chk("rst_wl",    words_loaded,     16'h0);
      reset = 1'b0;

      // No header yet, so the loader waits indefinitely without timing out.
      repeat (40) @(posedge clock);
      #1;
      chk("idle_no_timeout", {busy, done, error}, 3'b000);

      // Nominal load, sent back-to-back. The XOR of 02 00 34 12 78 56 is 0x0A.
      base = wr_n;
      send(8'h02);
      chk("nom_busy_lo", busy, 1'b0);
      send(8'h00);
      chk("nom_busy", busy, 1'b1);
      send(8'h34);
      send(8'h12);
      chk("nom_w0_sel",  {ram_select, ram_write_enable}, 2'b11);
      chk("nom_w0_addr", ram_address,    16'h0000);
      chk("nom_w0_data", ram_write_data, 16'h1234);
      chk("nom_w0_wl",   words_loaded,   16'd1);
      send(8'h78);
      chk("nom_strobe_1cyc", ram_select, 1'b0);
      send(8'h56);
      chk("nom_w1_addr", ram_address,    16'h0001);
      chk("nom_w1_data", ram_write_data, 16'h5678);
      chk("nom_w1_wl",   words_loaded,   16'd2);
      chk("nom_w1_busy", busy,           1'b1);
      send(8'h0A);
      chk("nom_flags", {busy, done, error}, 3'b010);
      chk("nom_wl",    words_loaded,   16'd2);
      chk("nom_nwr",   wr_n - base,    32'd2);
      send(8'h55);
      chk("nom_sticky", {done, error, ram_select}, 3'b100);

      // Checksum mismatch: both writes happen, then error.
      pulse_reset();
      base = wr_n;
      send(8'h02); send(8'h00); send(8'h34); send(8'h12);
      send(8'h78); send(8'h56); send(8'h09);
      chk("bad_flags", {busy, done, error}, 3'b001);
      chk("bad_nwr",   wr_n - base, 32'd2);
      chk("bad_log0",  {log_addr[base], log_data[base]},         32'h0000_1234);
      chk("bad_log1",  {log_addr[base+1], log_data[base+1]},     32'h0001_5678);

      // Zero length.
      pulse_reset();
      base = wr_n;
      send(8'h00); send(8'h00);
      chk("zero_busy", busy, 1'b1);
      send(8'h00);
      chk("zero_flags", {busy, done, error}, 3'b010);
      chk("zero_wl",    words_loaded, 16'd0);
      chk("zero_nwr",   wr_n - base,  32'd0);

      // N == DEPTH is accepted.
      pulse_reset();
      send(8'h00); send(8'h01);
      chk("depth_ok", {busy, error}, 2'b10);

      // Oversize header N=257.
      pulse_reset();
      base = wr_n;
      send(8'h01); send(8'h01);
      chk("over_flags", {busy, done, error}, 3'b001);
      send(8'h11); send(8'h22); send(8'h33);
      chk("over_sticky", {busy, done, error}, 3'b001);
      chk("over_nwr",    wr_n - base,  32'd0);
      chk("over_wl",     words_loaded, 16'd0);

      // Timeout: error appears after exactly 16 idle clocks.
      pulse_reset();
      base = wr_n;
      send(8'h01); send(8'h00); send(8'hAA);
      repeat (15) @(posedge clock);
      #1;
      chk("to_15", {busy, error}, 2'b10);
      @(posedge clock);
      #1;
      chk("to_16", {busy, done, error}, 3'b001);
      send(8'hBB);
      chk("to_sticky", {busy, done, error}, 3'b001);
      chk("to_nwr",    wr_n - base, 32'd0);

      // Reset mid-transfer, asserted while a write strobe is out.
      pulse_reset();
      send(8'h02); send(8'h00); send(8'h34); send(8'h12);
      chk("mid_pre_sel", ram_select, 1'b1);
      pulse_reset();
      chk("mid_rst_wr",    {ram_select, ram_write_enable, ram_address, ram_write_data}, 34'h0);
      chk("mid_rst_flags", {busy, done, error}, 3'b000);
      chk("mid_rst_wl",    words_loaded, 16'd0);
      base = wr_n;
      send(8'h01); send(8'h00); send(8'hCD); send(8'hAB);
      chk("fresh_addr", ram_address,    16'h0000);
      chk("fresh_data", ram_write_data, 16'hABCD);
      send(8'h67);
      chk("fresh_flags", {busy, done, error}, 3'b010);
      chk("fresh_wl",    words_loaded, 16'd1);
      chk("fresh_nwr",   wr_n - base,  32'd1);

      chk("sel_we_pair", bad_pair, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
